// File: rtl/wb_pkg.sv
// Shared types for the writeback stage: result-select encoding, FSM states, load funct3 codes.
// No logic; compile before every other wb_* file.
// Consumers import wb_pkg::* to use these names.
package wb_pkg;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2,
        WB_CSR = 2'd3
    } wb_sel_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_MEM = 2'd1,
        ST_DRAIN    = 2'd2
    } wb_state_e;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LD  = 3'd3;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_LWU = 3'd6;

endpackage

// File: rtl/wb_load_align.sv
// Picks the byte/half/word lane of a raw load word and sign- or zero-extends it to XLEN.
// Latency: purely combinational.
// Backpressure: none; only built when WB_LOAD_ALIGN_EN is defined.
module wb_load_align
    import wb_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int OW   = $clog2(XLEN/8)
) (
    input  logic [XLEN-1:0] raw,
    input  logic [2:0]      funct3,
    input  logic [OW-1:0]   off,
    output logic [XLEN-1:0] data
);

    logic [OW-1:0] h_off;
    logic [OW-1:0] w_off;
    logic [7:0]    b_lane;
    logic [15:0]   h_lane;
    logic [31:0]   w_lane;

    // Halves ignore the low offset bit, words ignore the low two (nothing left on RV32).
    assign h_off  = off & ~OW'(1);
    assign w_off  = off & ~OW'(3);
    assign b_lane = 8'(raw >> {off, 3'b000});
    assign h_lane = 16'(raw >> {h_off, 3'b000});
    assign w_lane = 32'(raw >> {w_off, 3'b000});

    // Extend the selected lane; LD, codes 3/6/7 on RV32 and 7 on RV64 pass the word through.
    always_comb begin
        data = raw;
        case (funct3)
            F3_LB:   data = XLEN'($signed(b_lane));
            F3_LH:   data = XLEN'($signed(h_lane));
            F3_LW:   data = XLEN'($signed(w_lane));
            F3_LBU:  data = XLEN'(b_lane);
            F3_LHU:  data = XLEN'(h_lane);
            F3_LWU:  data = (XLEN == 64) ? XLEN'(w_lane) : raw;
            F3_LD:   data = raw;
            default: data = raw;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Registered writeback: selects ALU/MEM/PC+4/CSR result and drives the register-file write port.
// Latency: non-load write one cycle after accept; load write one cycle after mem_rvalid_i.
// Backpressure: in_ready_o low while a load is outstanding or draining. Option: WB_LOAD_ALIGN_EN.
module wb_stage
    import wb_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic                        flush_i,
    input  logic [1:0]                  wb_sel_i,
    input  logic [REG_AW-1:0]           rd_i,
    input  logic                        rd_we_i,
    input  logic [XLEN-1:0]             alu_i,
    input  logic [XLEN-1:0]             pc_4_i,
    input  logic [XLEN-1:0]             csr_i,
    input  logic [2:0]                  ld_funct3_i,
    input  logic [$clog2(XLEN/8)-1:0]   ld_off_i,
    input  logic                        mem_rvalid_i,
    input  logic [XLEN-1:0]             mem_rdata_i,
    output logic                        rf_we_o,
    output logic [REG_AW-1:0]           rf_waddr_o,
    output logic [XLEN-1:0]             wb_o,
    output logic                        pend_valid_o,
    output logic [REG_AW-1:0]           pend_rd_o,
    output logic                        stall_o
);

    localparam int OW = $clog2(XLEN/8);

    wb_state_e         state;
    logic              accept;
    logic [REG_AW-1:0] lat_rd;
    logic              lat_we;
    logic [XLEN-1:0]   sel_dat;
    logic [XLEN-1:0]   load_dat;

`ifdef WB_LOAD_ALIGN_EN
    logic [2:0]        lat_f3;
    logic [OW-1:0]     lat_off;

    wb_load_align #(.XLEN(XLEN), .OW(OW)) u_align (
        .raw    (mem_rdata_i),
        .funct3 (lat_f3),
        .off    (lat_off),
        .data   (load_dat)
    );
`else
    // Memory already returns aligned, extended data; the load shape inputs go nowhere.
    logic unused_align;
    assign unused_align = ^{ld_funct3_i, ld_off_i};
    assign load_dat     = mem_rdata_i;
`endif

    assign in_ready_o   = (state == ST_IDLE);
    assign stall_o      = (state != ST_IDLE);
    assign accept       = in_valid_i & in_ready_o & ~flush_i;
    assign pend_valid_o = (state == ST_WAIT_MEM) & lat_we & (lat_rd != '0);
    assign pend_rd_o    = lat_rd;

    // Non-load result mux; the MEM code never reaches the write path from here.
    always_comb begin
        sel_dat = alu_i;
        case (wb_sel_e'(wb_sel_i))
            WB_ALU:  sel_dat = alu_i;
            WB_PC4:  sel_dat = pc_4_i;
            WB_CSR:  sel_dat = csr_i;
            default: sel_dat = alu_i;
        endcase
    end

    // Writeback FSM; rf_we_o is a single-cycle pulse, wb_o holds between writes. x0 is never written.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            rf_we_o    <= 1'b0;
            rf_waddr_o <= '0;
            wb_o       <= '0;
            lat_rd     <= '0;
            lat_we     <= 1'b0;
`ifdef WB_LOAD_ALIGN_EN
            lat_f3     <= '0;
            lat_off    <= '0;
`endif
        end else begin
            rf_we_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (wb_sel_e'(wb_sel_i) == WB_MEM) begin
                            lat_rd  <= rd_i;
                            lat_we  <= rd_we_i;
`ifdef WB_LOAD_ALIGN_EN
                            lat_f3  <= ld_funct3_i;
                            lat_off <= ld_off_i;
`endif
                            state   <= ST_WAIT_MEM;
                        end else begin
                            rf_we_o    <= rd_we_i & (rd_i != '0);
                            rf_waddr_o <= rd_i;
                            wb_o       <= sel_dat;
                        end
                    end
                end
                ST_WAIT_MEM: begin
                    // A flush wins over a coincident response, which is then dropped.
                    if (flush_i) begin
                        state <= mem_rvalid_i ? ST_IDLE : ST_DRAIN;
                    end else if (mem_rvalid_i) begin
                        rf_we_o    <= lat_we & (lat_rd != '0);
                        rf_waddr_o <= lat_rd;
                        wb_o       <= load_dat;
                        state      <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (mem_rvalid_i) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid_i;
    logic        in_ready_o;
    logic        flush_i;
    logic [1:0]  wb_sel_i;
    logic [4:0]  rd_i;
    logic        rd_we_i;
    logic [31:0] alu_i;
    logic [31:0] pc_4_i;
    logic [31:0] csr_i;
    logic [2:0]  ld_funct3_i;
    logic [1:0]  ld_off_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] wb_o;
    logic        pend_valid_o;
    logic [4:0]  pend_rd_o;
    logic        stall_o;

    int checks = 0;
    int passes = 0;

    wb_stage #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .flush_i      (flush_i),
        .wb_sel_i     (wb_sel_i),
        .rd_i         (rd_i),
        .rd_we_i      (rd_we_i),
        .alu_i        (alu_i),
        .pc_4_i       (pc_4_i),
        .csr_i        (csr_i),
        .ld_funct3_i  (ld_funct3_i),
        .ld_off_i     (ld_off_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i),
        .rf_we_o      (rf_we_o),
        .rf_waddr_o   (rf_waddr_o),
        .wb_o         (wb_o),
        .pend_valid_o (pend_valid_o),
        .pend_rd_o    (pend_rd_o),
        .stall_o      (stall_o)
    );

    always #5 clk = ~clk;

    // Reference load result from the RISC-V load rules, using plain arithmetic on lane numbers.
    function automatic logic [31:0] model_load(input logic [31:0] raw, input logic [2:0] f3, input logic [1:0] off);
`ifdef WB_LOAD_ALIGN_EN
        logic [31:0] b;
        logic [31:0] h;
        b = (raw >> (8 * int'(off))) & 32'hFF;
        h = (raw >> (16 * (int'(off) / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 32'd128)   ? (b + 32'hFFFF_FF00) : b;
            3'd1:    return (h >= 32'd32768) ? (h + 32'hFFFF_0000) : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return raw;
        endcase
`else
        if (f3 == 3'd7 && off == 2'd3) return raw;
        return raw;
`endif
    endfunction

    function automatic logic [31:0] model_sel(input logic [1:0] sel, input logic [31:0] a, input logic [31:0] p, input logic [31:0] c);
        if (sel == 2'd2) return p;
        if (sel == 2'd3) return c;
        return a;
    endfunction

    task automatic idle_inputs();
        in_valid_i   = 1'b0;
        flush_i      = 1'b0;
        wb_sel_i     = 2'd0;
        rd_i         = '0;
        rd_we_i      = 1'b0;
        alu_i        = '0;
        pc_4_i       = '0;
        csr_i        = '0;
        ld_funct3_i  = '0;
        ld_off_i     = '0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
    endtask

    task automatic present(input logic [1:0] sel, input logic [4:0] rd, input logic we,
                           input logic [31:0] a, input logic [31:0] p, input logic [31:0] c,
                           input logic [2:0] f3, input logic [1:0] off);
        in_valid_i  = 1'b1;
        wb_sel_i    = sel;
        rd_i        = rd;
        rd_we_i     = we;
        alu_i       = a;
        pc_4_i      = p;
        csr_i       = c;
        ld_funct3_i = f3;
        ld_off_i    = off;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        checks++; if (rf_we_o !== 1'b0) $display("FAIL reset_rf_we got %0b want 0", rf_we_o); else passes++;
        checks++; if (rf_waddr_o !== 5'd0) $display("FAIL reset_waddr got %0d want 0", rf_waddr_o); else passes++;
        checks++; if (wb_o !== 32'd0) $display("FAIL reset_wb got %h want 0", wb_o); else passes++;
        checks++; if (pend_valid_o !== 1'b0) $display("FAIL reset_pend_valid got %0b want 0", pend_valid_o); else passes++;
        checks++; if (pend_rd_o !== 5'd0) $display("FAIL reset_pend_rd got %0d want 0", pend_rd_o); else passes++;
        checks++; if (stall_o !== 1'b0) $display("FAIL reset_stall got %0b want 0", stall_o); else passes++;
        checks++; if (in_ready_o !== 1'b1) $display("FAIL reset_in_ready got %0b want 1", in_ready_o); else passes++;
        rst = 1'b1;
        @(negedge clk);
        checks++; if (in_ready_o !== 1'b1) $display("FAIL post_reset_in_ready got %0b want 1", in_ready_o); else passes++;
    endtask

    task automatic test_alu();
        present(2'd0, 5'd5, 1'b1, 32'h0000_1234, 32'h0, 32'h0, 3'd0, 2'd0);
        @(negedge clk);
        in_valid_i = 1'b0;
        checks++; if (rf_we_o !== 1'b1) $display("FAIL alu_we got %0b want 1", rf_we_o); else passes++;
        checks++; if (rf_waddr_o !== 5'd5) $display("FAIL alu_waddr got %0d want 5", rf_waddr_o); else passes++;
        checks++; if (wb_o !== 32'h0000_1234) $display("FAIL alu_wb got %h want 00001234", wb_o); else passes++;
        checks++; if (in_ready_o !== 1'b1) $display("FAIL alu_in_ready got %0b want 1", in_ready_o); else passes++;
        @(negedge clk);
        checks++; if (rf_we_o !== 1'b0) $display("FAIL alu_we_pulse got %0b want 0", rf_we_o); else passes++;
        checks++; if (wb_o !== 32'h0000_1234) $display("FAIL alu_wb_hold got %h want 00001234", wb_o); else passes++;
    endtask

    task automatic test_load_byte(input logic [2:0] f3);
        logic [31:0] exp;
        exp = model_load(32'h0080_0000, f3, 2'd2);
        present(2'd1, 5'd7, 1'b1, 32'h0, 32'h0, 32'h0, f3, 2'd2);
        @(negedge clk);
        in_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({stall_o, pend_valid_o, pend_rd_o} !== {1'b1, 1'b1, 5'd7})
                $display("FAIL load_pending cyc%0d got stall=%0b pend=%0b rd=%0d want 1 1 7", i, stall_o, pend_valid_o, pend_rd_o);
            else passes++;
            if (i < 2) @(negedge clk);
        end
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h0080_0000;
        @(negedge clk);
        mem_rvalid_i = 1'b0;
        checks++; if (rf_we_o !== 1'b1) $display("FAIL load_we f3=%0d got %0b want 1", f3, rf_we_o); else passes++;
        checks++; if (rf_waddr_o !== 5'd7) $display("FAIL load_waddr got %0d want 7", rf_waddr_o); else passes++;
        checks++; if (wb_o !== exp) $display("FAIL load_wb f3=%0d got %h want %h", f3, wb_o, exp); else passes++;
        checks++; if (stall_o !== 1'b0) $display("FAIL load_stall_after got %0b want 0", stall_o); else passes++;
    endtask

    task automatic test_jal_rd0();
        present(2'd2, 5'd0, 1'b1, 32'h0, 32'h0000_0104, 32'h0, 3'd0, 2'd0);
        @(negedge clk);
        in_valid_i = 1'b0;
        checks++; if (rf_we_o !== 1'b0) $display("FAIL jal_rd0_we got %0b want 0", rf_we_o); else passes++;
        checks++; if (wb_o !== 32'h0000_0104) $display("FAIL jal_rd0_wb got %h want 00000104", wb_o); else passes++;
    endtask

    task automatic test_flush_drain();
        present(2'd1, 5'd9, 1'b1, 32'h0, 32'h0, 32'h0, 3'd2, 2'd0);
        @(negedge clk);
        in_valid_i = 1'b0;
        flush_i    = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        checks++; if ({stall_o, in_ready_o, pend_valid_o} !== 3'b100)
            $display("FAIL drain_state got stall=%0b rdy=%0b pend=%0b want 1 0 0", stall_o, in_ready_o, pend_valid_o); else passes++;
        @(negedge clk);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = $urandom;
        present(2'd0, 5'd10, 1'b1, 32'h0000_CAFE, 32'h0, 32'h0, 3'd0, 2'd0);
        @(negedge clk);
        mem_rvalid_i = 1'b0;
        checks++; if (rf_we_o !== 1'b0) $display("FAIL drain_no_write got %0b want 0", rf_we_o); else passes++;
        checks++; if (in_ready_o !== 1'b1) $display("FAIL drain_ready_after got %0b want 1", in_ready_o); else passes++;
        @(negedge clk);
        in_valid_i = 1'b0;
        checks++; if ({rf_we_o, rf_waddr_o} !== {1'b1, 5'd10}) $display("FAIL drain_next_we got %0b/%0d want 1/10", rf_we_o, rf_waddr_o); else passes++;
        checks++; if (wb_o !== 32'h0000_CAFE) $display("FAIL drain_next_wb got %h want 0000cafe", wb_o); else passes++;
    endtask

    task automatic test_flush_coincident();
        present(2'd1, 5'd11, 1'b1, 32'h0, 32'h0, 32'h0, 3'd2, 2'd0);
        @(negedge clk);
        in_valid_i   = 1'b0;
        flush_i      = 1'b1;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = $urandom;
        @(negedge clk);
        flush_i      = 1'b0;
        mem_rvalid_i = 1'b0;
        checks++; if (rf_we_o !== 1'b0) $display("FAIL coinc_no_write got %0b want 0", rf_we_o); else passes++;
        checks++; if ({in_ready_o, stall_o} !== 2'b10) $display("FAIL coinc_idle got rdy=%0b stall=%0b want 1 0", in_ready_o, stall_o); else passes++;
    endtask

    task automatic test_idle_rvalid();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = $urandom;
        @(negedge clk);
        mem_rvalid_i = 1'b0;
        checks++; if ({rf_we_o, in_ready_o} !== 2'b01) $display("FAIL idle_rvalid got we=%0b rdy=%0b want 0 1", rf_we_o, in_ready_o); else passes++;
        checks++; if (wb_o !== 32'h0000_CAFE) $display("FAIL idle_rvalid_wb got %h want 0000cafe", wb_o); else passes++;
    endtask

    task automatic test_reset_mid_load();
        present(2'd1, 5'd12, 1'b1, 32'h0, 32'h0, 32'h0, 3'd2, 2'd0);
        @(negedge clk);
        in_valid_i = 1'b0;
        checks++; if (pend_valid_o !== 1'b1) $display("FAIL midrst_pend_before got %0b want 1", pend_valid_o); else passes++;
        #1 rst = 1'b0;
        #1;
        checks++;
        if ({rf_we_o, rf_waddr_o, wb_o, pend_valid_o, pend_rd_o, stall_o, in_ready_o} !== {1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 1'b1})
            $display("FAIL midrst_outputs got we=%0b wa=%0d wb=%h pv=%0b prd=%0d st=%0b rdy=%0b want 0 0 0 0 0 0 1",
                     rf_we_o, rf_waddr_o, wb_o, pend_valid_o, pend_rd_o, stall_o, in_ready_o);
        else passes++;
        @(negedge clk);
        rst          = 1'b1;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hDEAD_BEEF;
        @(negedge clk);
        mem_rvalid_i = 1'b0;
        checks++; if ({rf_we_o, stall_o} !== 2'b00) $display("FAIL midrst_stale got we=%0b stall=%0b want 0 0", rf_we_o, stall_o); else passes++;
        checks++; if (wb_o !== 32'd0) $display("FAIL midrst_stale_wb got %h want 0", wb_o); else passes++;
    endtask

    task automatic test_back_to_back();
        logic        exp_we;
        logic [4:0]  exp_rd;
        logic [31:0] exp_wb;
        logic [1:0]  sel;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] a, p, c;
        int          s;
        exp_we = 1'b0; exp_rd = '0; exp_wb = '0;
        for (int i = 0; i <= 16; i++) begin
            if (i > 0) begin
                checks++; if ({rf_we_o, rf_waddr_o} !== {exp_we, exp_rd})
                    $display("FAIL b2b_we[%0d] got %0b/%0d want %0b/%0d", i, rf_we_o, rf_waddr_o, exp_we, exp_rd); else passes++;
                checks++; if (wb_o !== exp_wb) $display("FAIL b2b_wb[%0d] got %h want %h", i, wb_o, exp_wb); else passes++;
                checks++; if (in_ready_o !== 1'b1) $display("FAIL b2b_ready[%0d] got %0b want 1", i, in_ready_o); else passes++;
            end
            if (i < 16) begin
                s   = $urandom_range(0, 2);
                sel = (s == 0) ? 2'd0 : (s == 1) ? 2'd2 : 2'd3;
                rd  = 5'($urandom_range(0, 31));
                we  = 1'($urandom_range(0, 1));
                a = $urandom; p = $urandom; c = $urandom;
                present(sel, rd, we, a, p, c, 3'd0, 2'd0);
                exp_we = we && (rd != 5'd0);
                exp_rd = rd;
                exp_wb = model_sel(sel, a, p, c);
                @(negedge clk);
            end else begin
                in_valid_i = 1'b0;
            end
        end
    endtask

    task automatic test_random();
        logic [1:0]  sel;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] a, p, c, raw, exp;
        logic [2:0]  f3;
        logic [1:0]  off;
        int          lat;
        for (int n = 0; n < 30; n++) begin
            sel = 2'($urandom_range(0, 3));
            rd  = 5'($urandom_range(0, 31));
            we  = 1'($urandom_range(0, 1));
            a = $urandom; p = $urandom; c = $urandom; raw = $urandom;
            f3  = 3'($urandom_range(0, 7));
            off = 2'($urandom_range(0, 3));
            present(sel, rd, we, a, p, c, f3, off);
            @(negedge clk);
            in_valid_i = 1'b0;
            if (sel == 2'd1) begin
                lat = $urandom_range(1, 4);
                for (int k = 1; k <= lat; k++) begin
                    checks++;
                    if ({pend_valid_o, pend_rd_o, in_ready_o} !== {we && (rd != 5'd0), rd, 1'b0})
                        $display("FAIL rnd_pend[%0d] got pv=%0b rd=%0d rdy=%0b want %0b %0d 0", n, pend_valid_o, pend_rd_o, in_ready_o, we && (rd != 5'd0), rd);
                    else passes++;
                    if (k < lat) @(negedge clk);
                end
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = raw;
                @(negedge clk);
                mem_rvalid_i = 1'b0;
                exp = model_load(raw, f3, off);
            end else begin
                exp = model_sel(sel, a, p, c);
            end
            checks++; if ({rf_we_o, rf_waddr_o} !== {we && (rd != 5'd0), rd})
                $display("FAIL rnd_we[%0d] got %0b/%0d want %0b/%0d", n, rf_we_o, rf_waddr_o, we && (rd != 5'd0), rd); else passes++;
            checks++; if (wb_o !== exp) $display("FAIL rnd_wb[%0d] sel=%0d f3=%0d off=%0d got %h want %h", n, sel, f3, off, wb_o, exp); else passes++;
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_byte(3'd0);
        test_load_byte(3'd4);
        test_jal_rd0();
        test_flush_drain();
        test_idle_rvalid();
        test_flush_coincident();
        test_back_to_back();
        test_random();
        test_reset_mid_load();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
